cache_ctrl: RTL
===============

# cache_ctrl

Sequencing controller for the 2-way set-associative instruction/data read cache. It owns the set RAM port, performs tag lookup, selects the victim with a per-set MRU bit, refills a missed line from backing memory over a req/ack handshake, and clears all sets after reset or on flush. It sits between the CPU fetch/load path and the main-memory interface.

## Interface
- eC, 13: log2 cache size in words
- ew, 2: log2 words per line; W = 2^ew words per line
- eS, eC-ew-1: log2 number of sets; S = 2^eS (two ways per set)
- A, 32: word-address width
- D, 16: data word width
- Derived: T = A-eS-ew tag bits; L = D*W line bits; E = 3+2*(T+L) set-entry bits

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  A  word address; sampled with cpu_re in IDLE
- cpu_re  in  1  read request
- cpu_ready  out  1  one-cycle pulse, cpu_rdata valid
- cpu_rdata  out  D  read data, 0 when cpu_ready low
- flush  in  1  invalidate whole cache (sampled in IDLE only)
- busy  out  1  high in every state except IDLE
- mem_req  out  1  backing-memory word request
- mem_addr  out  A  backing-memory word address
- mem_ack  in  1  one-cycle pulse, mem_rdata valid
- mem_rdata  in  D  backing-memory data
- ram_addr  out  eS  set index
- ram_we  out  1  set RAM write enable
- ram_wdata  out  E  set entry to write
- ram_rdata  in  E  set entry; synchronous read, valid the cycle after ram_addr presented

## Operation
- Address split: block = addr[ew-1:0], set = addr[ew+eS-1:ew], tag = addr[A-1:ew+eS].
- Entry layout MSB->LSB: {mru, valid0, valid1, tag0, line0, tag1, line1}; word k of a line at bits [k*D +: D]. mru=1 means way1 most recently used.
- States: INIT, IDLE, LOOKUP, FILL, WRITE.
- INIT: counter c from 0; ram_addr=c, ram_we=1, ram_wdata=0; c==S-1 -> IDLE. Takes exactly S cycles.
- IDLE: flush -> INIT (c=0), priority over cpu_re. Else cpu_re -> latch cpu_addr, drive ram_addr=set, -> LOOKUP.
- LOOKUP: hitN = validN && tagN==tag. hit0 has priority if both (illegal, must not occur). Hit: cpu_ready=1, cpu_rdata=word, write entry back with mru=hit way, other fields unchanged; -> IDLE. Miss: latch entry; victim = way0 if !valid0, else way1 if !valid1, else !mru; word counter k=0; -> FILL.
- FILL: mem_req=1, mem_addr={tag, set, k}. On mem_ack: buffer[k]=mem_rdata, k++ ; after k==W-1 acked -> WRITE. mem_req stays high continuously; mem_addr changes only the cycle after an ack.
- WRITE: ram_we=1, ram_wdata = latched entry with victim tag/line replaced, victim valid=1, mru=victim; cpu_ready=1, cpu_rdata=buffer[block]; -> IDLE.
- mem_ack outside FILL is ignored. cpu_re outside IDLE is ignored; a cpu_re still high in IDLE after a response starts a new request.

## Timing
- During rst: state=INIT, c=0, k=0; cpu_ready=0, cpu_rdata=0, mem_req=0, mem_addr=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=1. INIT writes start the cycle after rst falls.
- Reset in any state (including mid-FILL) aborts: mem_req low from the reset cycle, partial line discarded, full INIT re-run.
- Hit: cpu_re sampled in IDLE at edge n -> cpu_ready high in cycle n+1 (1-cycle latency); back in IDLE at n+2.
- Miss: cpu_ready in the cycle after the W-th mem_ack; with ack every cycle on immediate req, latency = W+2 cycles.
- Only one ram_we write per request (LOOKUP hit or WRITE). No RAM read and write in the same cycle.

## Test plan
- Reset release -> ram_we high exactly 1024 cycles with ram_addr 0..1023 and ram_wdata=0, busy drops at cycle 1025, cpu_ready never asserted.
- Cold read addr 0x00001234 (set 0x08D, tag 1, block 0), memory returns 0xA000+k per word, ack 1 cycle after each req address -> mem_addr 0x1234..0x1237 in order, cpu_rdata=0xA000, entry written valid0=1 tag0=1 mru=0.
- Read 0x00001236 after it -> hit, cpu_ready at 1 cycle, cpu_rdata=0xA002, mem_req stays 0.
- Read 0x00002234 then 0x00003234 (same set) -> first fills way1 (mru=1); second evicts way0 (LRU); subsequent read of 0x00001234 misses, 0x00002234 hits.
- flush pulse in IDLE with flush and cpu_re both high -> INIT runs 1024 cycles, request ignored; next read of 0x00001234 misses.
- rst asserted after 2nd mem_ack of a fill -> mem_req 0 in same cycle, no cpu_ready, INIT completes, stray mem_ack during INIT has no effect.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// Bus bundle for cache_ctrl: CPU read port, backing-memory word port and set-RAM port.
// The controller uses the master view; the surrounding system uses the slave view.
interface cache_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int SET_W   = 10,
  parameter int ENTRY_W = 171
);
  logic [ADDR_W-1:0]  cpu_addr;
  logic               cpu_re;
  logic               cpu_ready;
  logic [DATA_W-1:0]  cpu_rdata;
  logic               flush;
  logic               busy;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [DATA_W-1:0]  mem_rdata;
  logic [SET_W-1:0]   ram_addr;
  logic               ram_we;
  logic [ENTRY_W-1:0] ram_wdata;
  logic [ENTRY_W-1:0] ram_rdata;

  modport master (
    input  cpu_addr, cpu_re, flush, mem_ack, mem_rdata, ram_rdata,
    output cpu_ready, cpu_rdata, busy, mem_req, mem_addr, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    output cpu_addr, cpu_re, flush, mem_ack, mem_rdata, ram_rdata,
    input  cpu_ready, cpu_rdata, busy, mem_req, mem_addr, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// Sequencing controller for a 2-way set-associative read cache: lookup, MRU-based
// victim choice, word-by-word refill from backing memory, and set clearing on reset/flush.
module cache_ctrl #(
  parameter int LOG_WORDS = 13,
  parameter int LOG_LINE  = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.master bus
);
  localparam int LOG_SETS = LOG_WORDS - LOG_LINE - 1;
  localparam int WORDS    = 1 << LOG_LINE;
  localparam int TAG_W    = ADDR_W - LOG_SETS - LOG_LINE;
  localparam int LINE_W   = DATA_W * WORDS;
  localparam int ENTRY_W  = 3 + 2 * (TAG_W + LINE_W);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_FILL   = 3'd3,
    ST_WRITE  = 3'd4
  } state_t;

  typedef struct packed {
    logic              mru;
    logic              valid0;
    logic              valid1;
    logic [TAG_W-1:0]  tag0;
    logic [LINE_W-1:0] line0;
    logic [TAG_W-1:0]  tag1;
    logic [LINE_W-1:0] line1;
  } entry_t;

  function automatic logic [DATA_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                                input logic [LOG_LINE-1:0] blk);
    return line[blk*DATA_W +: DATA_W];
  endfunction

  state_t                         state_r, state_n;
  logic [LOG_SETS-1:0]            set_cnt_r;
  logic [LOG_LINE-1:0]            word_cnt_r;
  logic [ADDR_W-1:0]              addr_r;
  entry_t                         entry_r;
  logic                           victim_r;
  logic [WORDS-1:0][DATA_W-1:0]   line_buf_r;

  entry_t                         rd_entry_s;
  entry_t                         upd_entry_s;
  logic [TAG_W-1:0]               req_tag_s;
  logic [LOG_SETS-1:0]            req_set_s;
  logic [LOG_LINE-1:0]            req_blk_s;
  logic                           hit0_s, hit1_s, victim_s;

  logic                           cpu_ready_s, mem_req_s, ram_we_s;
  logic [DATA_W-1:0]              cpu_rdata_s;
  logic [ADDR_W-1:0]              mem_addr_s;
  logic [LOG_SETS-1:0]            ram_addr_s;
  entry_t                         ram_wdata_s;

  assign req_tag_s  = addr_r[ADDR_W-1 -: TAG_W];
  assign req_set_s  = addr_r[LOG_LINE +: LOG_SETS];
  assign req_blk_s  = addr_r[LOG_LINE-1:0];
  assign rd_entry_s = entry_t'(bus.ram_rdata);
  assign hit0_s     = rd_entry_s.valid0 && (rd_entry_s.tag0 == req_tag_s);
  assign hit1_s     = rd_entry_s.valid1 && (rd_entry_s.tag1 == req_tag_s);
  // Fill an empty way first; with both ways valid evict the least recently used one.
  assign victim_s   = !rd_entry_s.valid0 ? 1'b0 : (!rd_entry_s.valid1 ? 1'b1 : !rd_entry_s.mru);

  // Next-state and per-state output decode.
  always_comb begin
    state_n     = state_r;
    ram_addr_s  = req_set_s;
    ram_we_s    = 1'b0;
    ram_wdata_s = entry_t'({ENTRY_W{1'b0}});
    cpu_ready_s = 1'b0;
    cpu_rdata_s = {DATA_W{1'b0}};
    mem_req_s   = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    upd_entry_s = rd_entry_s;
    case (state_r)
      ST_INIT: begin
        ram_addr_s = set_cnt_r;
        ram_we_s   = 1'b1;
        if (set_cnt_r == {LOG_SETS{1'b1}}) state_n = ST_IDLE;
        else                               state_n = ST_INIT;
      end
      ST_IDLE: begin
        if (bus.flush) begin
          state_n = ST_INIT;
        end else if (bus.cpu_re) begin
          ram_addr_s = bus.cpu_addr[LOG_LINE +: LOG_SETS];
          state_n    = ST_LOOKUP;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (hit0_s || hit1_s) begin
          upd_entry_s.mru = !hit0_s;
          ram_we_s        = 1'b1;
          ram_wdata_s     = upd_entry_s;
          cpu_ready_s     = 1'b1;
          cpu_rdata_s     = hit0_s ? word_of(rd_entry_s.line0, req_blk_s)
                                   : word_of(rd_entry_s.line1, req_blk_s);
          state_n         = ST_IDLE;
        end else begin
          state_n = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_req_s  = 1'b1;
        mem_addr_s = {req_tag_s, req_set_s, word_cnt_r};
        if (bus.mem_ack && (word_cnt_r == {LOG_LINE{1'b1}})) state_n = ST_WRITE;
        else                                                  state_n = ST_FILL;
      end
      ST_WRITE: begin
        upd_entry_s     = entry_r;
        upd_entry_s.mru = victim_r;
        if (victim_r) begin
          upd_entry_s.valid1 = 1'b1;
          upd_entry_s.tag1   = req_tag_s;
          upd_entry_s.line1  = line_buf_r;
        end else begin
          upd_entry_s.valid0 = 1'b1;
          upd_entry_s.tag0   = req_tag_s;
          upd_entry_s.line0  = line_buf_r;
        end
        ram_we_s    = 1'b1;
        ram_wdata_s = upd_entry_s;
        cpu_ready_s = 1'b1;
        cpu_rdata_s = line_buf_r[req_blk_s];
        state_n     = ST_IDLE;
      end
      default: begin
        state_n = ST_INIT;
      end
    endcase
  end

  // State register plus clear counter, request latch and refill buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      set_cnt_r  <= {LOG_SETS{1'b0}};
      word_cnt_r <= {LOG_LINE{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      entry_r    <= entry_t'({ENTRY_W{1'b0}});
      victim_r   <= 1'b0;
      line_buf_r <= {LINE_W{1'b0}};
    end else begin
      state_r <= state_n;
      case (state_r)
        ST_INIT: begin
          set_cnt_r <= set_cnt_r + LOG_SETS'(1);
        end
        ST_IDLE: begin
          if (bus.flush) begin
            set_cnt_r <= {LOG_SETS{1'b0}};
          end else if (bus.cpu_re) begin
            addr_r <= bus.cpu_addr;
          end
        end
        ST_LOOKUP: begin
          if (!(hit0_s || hit1_s)) begin
            entry_r    <= rd_entry_s;
            victim_r   <= victim_s;
            word_cnt_r <= {LOG_LINE{1'b0}};
          end
        end
        ST_FILL: begin
          if (bus.mem_ack) begin
            line_buf_r[word_cnt_r] <= bus.mem_rdata;
            word_cnt_r             <= word_cnt_r + LOG_LINE'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Reset forces every output quiet in the very cycle it is asserted, aborting any refill.
  assign bus.cpu_ready = cpu_ready_s & ~rst;
  assign bus.cpu_rdata = rst ? {DATA_W{1'b0}} : cpu_rdata_s;
  assign bus.mem_req   = mem_req_s & ~rst;
  assign bus.mem_addr  = rst ? {ADDR_W{1'b0}} : mem_addr_s;
  assign bus.ram_we    = ram_we_s & ~rst;
  assign bus.ram_addr  = rst ? {LOG_SETS{1'b0}} : ram_addr_s;
  assign bus.ram_wdata = rst ? {ENTRY_W{1'b0}} : ram_wdata_s;
  assign bus.busy      = rst | (state_r != ST_IDLE);
endmodule
